mul_unit_ctrl: RTL and testbench



---
 rtl/mul_unit_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mul_unit_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit_ctrl.sv
// mul_unit_ctrl
// Sequencer between execute-stage issue and a 33x33 two-stage pipelined
// multiplier. It forms the 33-bit signed/unsigned operands for the four
// RV32M multiply ops and drives the multiplier clock enable. A shadow
// pipeline of {valid, op, tag} moves in lock-step with the multiplier
// stages. The final stage selects the low or high product word and
// presents it to writeback, in issue order and with its tag.
//
// Build option MUL_SKID_EN: adds a one-entry output skid register. With
// it, mul_ce and req_ready depend only on registered state, so there is
// no combinational path from resp_ready back to the issue side. Without
// it, a stalled result freezes the pipeline in the same cycle.
module mul_unit_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic [32:0]      mul_a,
    output logic [32:0]      mul_b,
    output logic             mul_ce,
    input  logic [65:0]      mul_p
);

    // Number of shadow stages; this must match the multiplier pipeline depth.
    localparam int NSTG = 2;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    logic             accept;
    logic             s2_valid;
    logic [1:0]       s2_op;
    logic [TAG_W-1:0] s2_tag;
    logic [31:0]      s2_data;

    // Only the low 64 product bits are ever architecturally visible.
    logic             mul_p_unused;
    assign mul_p_unused = ^mul_p[65:64];

    // Operand extension: the 33rd bit is the sign for signed operands, else 0
    always_comb begin
        mul_a = {1'b0, req_a};
        mul_b = {1'b0, req_b};
        if (req_op != OP_MULHU) begin
            mul_a[32] = req_a[31];
        end
        if ((req_op == OP_MUL) || (req_op == OP_MULH)) begin
            mul_b[32] = req_b[31];
        end
    end

    assign accept = req_valid & req_ready;

    // Shadow pipeline. Stage 0 loads the request side; later stages take
    // the previous stage. All stages advance only when the multiplier does.
    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_stage
            logic             valid_reg;
            logic             valid_next;
            logic [1:0]       op_reg;
            logic [1:0]       op_next;
            logic [TAG_W-1:0] tag_reg;
            logic [TAG_W-1:0] tag_next;
            logic             in_valid;
            logic [1:0]       in_op;
            logic [TAG_W-1:0] in_tag;

            if (gi == 0) begin : g_head
                assign in_valid = accept;
                assign in_op    = req_op;
                assign in_tag   = req_tag;
            end else begin : g_tail
                assign in_valid = g_stage[gi-1].valid_reg;
                assign in_op    = g_stage[gi-1].op_reg;
                assign in_tag   = g_stage[gi-1].tag_reg;
            end

            // Stage next-state: shift with the multiplier; flush kills the slot
            always_comb begin
                valid_next = valid_reg;
                op_next    = op_reg;
                tag_next   = tag_reg;
                if (mul_ce) begin
                    valid_next = in_valid;
                    op_next    = in_op;
                    tag_next   = in_tag;
                end
                if (flush) begin
                    valid_next = 1'b0;
                end
            end

            // Stage registers; reset discards any in-flight op at once
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    op_reg    <= 2'b00;
                    tag_reg   <= '0;
                end else begin
                    valid_reg <= valid_next;
                    op_reg    <= op_next;
                    tag_reg   <= tag_next;
                end
            end
        end
    endgenerate

    assign s2_valid = g_stage[NSTG-1].valid_reg;
    assign s2_op    = g_stage[NSTG-1].op_reg;
    assign s2_tag   = g_stage[NSTG-1].tag_reg;

    // MUL returns the low word; MULH/MULHSU/MULHU return the high word.
    assign s2_data  = (s2_op == OP_MUL) ? mul_p[31:0] : mul_p[63:32];

`ifdef MUL_SKID_EN
    logic             k_valid_reg;
    logic             k_valid_next;
    logic [31:0]      k_data_reg;
    logic [31:0]      k_data_next;
    logic [TAG_W-1:0] k_tag_reg;
    logic [TAG_W-1:0] k_tag_next;

    // The pipeline runs whenever the skid entry is free. A result that is
    // refused at S2 parks in the skid entry while the pipe keeps moving
    // for one more edge.
    assign mul_ce    = ~k_valid_reg;
    assign req_ready = ~k_valid_reg & ~flush;

    // Skid next-state: drain on acceptance, capture a refused S2 result
    always_comb begin
        k_valid_next = k_valid_reg;
        k_data_next  = k_data_reg;
        k_tag_next   = k_tag_reg;
        if (k_valid_reg && resp_ready) begin
            k_valid_next = 1'b0;
        end
        if (mul_ce && s2_valid && !resp_ready) begin
            k_valid_next = 1'b1;
            k_data_next  = s2_data;
            k_tag_next   = s2_tag;
        end
        if (flush) begin
            k_valid_next = 1'b0;
        end
    end

    // Skid register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_valid_reg <= 1'b0;
            k_data_reg  <= '0;
            k_tag_reg   <= '0;
        end else begin
            k_valid_reg <= k_valid_next;
            k_data_reg  <= k_data_next;
            k_tag_reg   <= k_tag_next;
        end
    end

    // The skid entry is always older than S2, so it is presented first.
    assign resp_valid = k_valid_reg | s2_valid;
    assign resp_data  = k_valid_reg ? k_data_reg : s2_data;
    assign resp_tag   = k_valid_reg ? k_tag_reg  : s2_tag;
`else
    // The pipeline freezes only when a finished result is being refused.
    assign mul_ce     = ~s2_valid | resp_ready;
    assign req_ready  = mul_ce & ~flush;

    assign resp_valid = s2_valid;
    assign resp_data  = s2_data;
    assign resp_tag   = s2_tag;
`endif

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Testbench for mul_unit_ctrl: table-driven op vectors plus directed
// stall, flush and reset sequences, with a behavioural two-stage multiplier.
`timescale 1ns/1ps
module tb_mul_unit_ctrl;

    localparam int TAG_W = 5;
    localparam int NVEC  = 12;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic [32:0]      mul_a;
    logic [32:0]      mul_b;
    logic             mul_ce;
    logic [65:0]      mul_p;

    logic [65:0]      mul_prod;
    logic [65:0]      mul_p1 = '0;
    logic [65:0]      mul_p2 = '0;

    int               n_vec  = 0;
    int               n_miss = 0;
    int               cyc    = 0;
    logic             lat_chk = 1'b1;
    logic [31:0]      exp_data = '0;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [31:0]      acc_cyc;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    logic             hold_pend = 1'b0;
    logic [31:0]      hold_data = '0;
    logic [TAG_W-1:0] hold_tag  = '0;

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             ea;
        logic             eb;
    } vec_t;

    vec_t vecs [NVEC];

    mul_unit_ctrl #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ce     (mul_ce),
        .mul_p      (mul_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural multiplier: sign-extend to 66 bits, two enabled stages.
    assign mul_prod = {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};
    always @(posedge clk) begin
        if (mul_ce) begin
            mul_p1 <= mul_prod;
            mul_p2 <= mul_p1;
        end
    end
    assign mul_p = mul_p2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int req);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Response monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_valid", {65'd0, resp_valid}, 66'd1);
                check("stall_data", {34'd0, resp_data}, {34'd0, hold_data});
                check("stall_tag", {61'd0, resp_tag}, {61'd0, hold_tag});
            end
            hold_pend = resp_valid && !resp_ready && !flush;
            hold_data = resp_data;
            hold_tag  = resp_tag;
            if (resp_valid && resp_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_resp_tag", int'(resp_tag), -1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_data", {34'd0, resp_data}, {34'd0, mon_e.data});
                    check("resp_tag", {61'd0, resp_tag}, {61'd0, mon_e.tag});
                    if (lat_chk) begin
                        check("latency", {34'd0, 32'(cyc) - mon_e.acc_cyc}, 66'd2);
                    end
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (req_valid && req_ready) begin
                sb_q.push_back('{data: exp_data, tag: req_tag, acc_cyc: 32'(cyc)});
            end
        end
    end

    // Present one request at posedge+1 and hold it until accepted.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [31:0] data,
                         input logic ea, input logic eb);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        exp_data  = data;
        @(negedge clk);
        check("mul_a", {33'd0, mul_a}, {33'd0, ea, a});
        check("mul_b", {33'd0, mul_b}, {33'd0, eb, b});
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("accept_timeout_cycles", n, 40);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_outstanding", 66'(sb_q.size()), 66'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b1;

        //          op     a             b             tag    result        ea    eb
        vecs[0]  = '{2'b00, 32'h00000007, 32'h00000006, 5'd1,  32'h0000002A, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 1'b1, 1'b1};
        vecs[2]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 1'b1, 1'b1};
        vecs[5]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[6]  = '{2'b11, 32'h80000000, 32'h00000002, 5'd7,  32'h00000001, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 32'h80000000, 32'h00000002, 5'd8,  32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[8]  = '{2'b10, 32'h00000002, 32'h80000000, 5'd9,  32'h00000001, 1'b0, 1'b0};
        vecs[9]  = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd10, 32'h3FFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{2'b00, 32'h12345678, 32'h00000010, 5'd11, 32'h23456780, 1'b0, 1'b0};
        vecs[11] = '{2'b01, 32'hFFFFFFF9, 32'h00000006, 5'd12, 32'hFFFFFFFF, 1'b1, 1'b0};

        // Reset state
        #2;
        check("rst_resp_valid", {65'd0, resp_valid}, 66'd0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", {65'd0, req_ready}, 66'd1);
        check("rst_mul_ce", {65'd0, mul_ce}, 66'd1);
        check("rst_resp_valid2", {65'd0, resp_valid}, 66'd0);
        check("rst_resp_tag", {61'd0, resp_tag}, 66'd0);

        // Table: all ops back to back, each response exactly two cycles after accept
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].data,
                  vecs[i].ea, vecs[i].eb);
        end
        wait_drain();

        // Backpressure: resp_ready low for three cycles mid-stream
        lat_chk = 1'b0;
        fork
            begin
                issue(2'b00, 32'h00000003, 32'h00000005, 5'd20, 32'h0000000F, 1'b0, 1'b0);
                issue(2'b11, 32'hFFFFFFFF, 32'h00000010, 5'd21, 32'h0000000F, 1'b0, 1'b0);
                issue(2'b01, 32'h40000000, 32'h00000004, 5'd22, 32'h00000001, 1'b0, 1'b0);
                issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, 32'h00000001, 1'b1, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                resp_ready = 1'b0;
                @(negedge clk);
`ifdef MUL_SKID_EN
                check("stall_ready_first", {65'd0, req_ready}, 66'd1);
`else
                check("stall_ready_first", {65'd0, req_ready}, 66'd0);
`endif
                @(posedge clk);
                #1;
                @(negedge clk);
                check("stall_ready_second", {65'd0, req_ready}, 66'd0);
                check("stall_held_tag", {61'd0, resp_tag}, 66'd21);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                resp_ready = 1'b1;
            end
        join
        wait_drain();
        lat_chk = 1'b1;

        // Flush with two ops in flight; a request during the flush is refused
        issue(2'b00, 32'h00000002, 32'h00000003, 5'd24, 32'h00000006, 1'b0, 1'b0);
        issue(2'b00, 32'h00000004, 32'h00000005, 5'd25, 32'h00000014, 1'b0, 1'b0);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_tag   = 5'd26;
        @(negedge clk);
        check("flush_req_ready", {65'd0, req_ready}, 66'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_resp_valid", {65'd0, resp_valid}, 66'd0);
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd27, 32'hFFFFFFFE, 1'b0, 1'b0);
        check("flush_second_dropped", {65'd0, resp_valid}, 66'd0);
        wait_drain();

        // Asynchronous reset mid-stream
        issue(2'b00, 32'h00000009, 32'h00000009, 5'd28, 32'h00000051, 1'b0, 1'b0);
        issue(2'b01, 32'h80000000, 32'h80000000, 5'd29, 32'h40000000, 1'b1, 1'b1);
        check("pre_reset_valid", {65'd0, resp_valid}, 66'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", {65'd0, resp_valid}, 66'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", {65'd0, req_ready}, 66'd1);
        check("post_reset_valid", {65'd0, resp_valid}, 66'd0);
        issue(2'b10, 32'hFFFFFFFE, 32'h00000003, 5'd30, 32'hFFFFFFFF, 1'b1, 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
